// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants (default DBIT/SB_TICK, oversampling OVS=16, mid-bit MID=7) and receiver FSM state type
package uart_pkg;
  localparam int DBIT_DEF = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVS = 16;
  localparam int MID = OVS / 2 - 1;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an async input; clk, reset (sync, active-high), i_d async in, o_q synchronized out, both flops reset to RST_VAL
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_q;
  always_ff @(posedge clk) r_q <= reset ? {2{RST_VAL}} : {r_q[0], i_d};
  assign o_q = r_q[1];
endmodule

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 16x oversampled UART receiver; clk, reset, rx (async serial, idle high), s_tick (16x baud) -> dout (last word), rx_done_tick (1-clk frame pulse), frame_err (stop sample low)
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int DBIT = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);
  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT);
  state_t r_state, w_state;
  logic [SW-1:0] r_s, w_s;
  logic [NW-1:0] r_n, w_n;
  logic [DBIT-1:0] r_b, w_b, r_dout, w_dout;
  logic r_done, w_done, r_ferr, w_ferr, w_rx_s;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .i_d(rx), .o_q(w_rx_s));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s <= '0;
      r_n <= '0;
      r_b <= '0;
      r_dout <= '0;
      r_done <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_state <= w_state;
      r_s <= w_s;
      r_n <= w_n;
      r_b <= w_b;
      r_dout <= w_dout;
      r_done <= w_done;
      r_ferr <= w_ferr;
    end
  end
  always_comb begin
    w_state = r_state;
    w_s = r_s;
    w_n = r_n;
    w_b = r_b;
    w_dout = r_dout;
    w_done = 1'b0;
    w_ferr = r_ferr;
    case (r_state)
      IDLE:
        if (!w_rx_s) begin
          w_state = START;
          w_s = '0;
        end
      START:
        if (s_tick) begin
          if (r_s == SW'(MID)) begin
            w_state = w_rx_s ? IDLE : DATA;
            w_s = '0;
            w_n = '0;
          end else w_s = r_s + 1'b1;
        end
      DATA:
        if (s_tick) begin
          if (r_s == SW'(OVS - 1)) begin
            w_s = '0;
            w_b = {w_rx_s, r_b[DBIT-1:1]};
            w_state = (r_n == NW'(DBIT - 1)) ? STOP : DATA;
            w_n = (r_n == NW'(DBIT - 1)) ? r_n : r_n + 1'b1;
          end else w_s = r_s + 1'b1;
        end
      STOP:
        if (s_tick) begin
          if (r_s == SW'(SB_TICK - 1)) begin
            w_state = IDLE;
            w_s = '0;
            w_done = 1'b1;
            w_dout = r_b;
            w_ferr = ~w_rx_s;
          end else w_s = r_s + 1'b1;
        end
      default: w_state = IDLE;
    endcase
  end
  assign dout = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err = r_ferr;
endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: randomized frame stimulus checked against a frame-level reference queue
module tb_uart_rx_unit;
  localparam int BITC = 64;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, s_tick = 1'b0;
  logic [7:0] dout;
  logic rx_done_tick, frame_err;
  int n_chk = 0, n_fail = 0, cyc = 0, n_sent = 0;
  typedef struct {logic [7:0] d; logic fe; int t0;} exp_t;
  exp_t exp_q[$];
  int pulse_q[$];
  logic [7:0] last_d = 8'h00;
  logic last_fe = 1'b0;
  uart_rx_unit dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1 s_tick = (cyc % 4 == 0);
    end
  end
  always @(negedge clk) begin
    if (!reset && rx_done_tick) begin
      exp_t e;
      pulse_q.push_back(cyc);
      check("pulse_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout", dout, e.d);
        check("frame_err", frame_err, e.fe);
        check("latency", (cyc - e.t0 >= 606) && (cyc - e.t0 <= 614), 1);
        last_d = e.d;
        last_fe = e.fe;
      end
    end
  end
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask
  task automatic send(input logic [7:0] d, input logic stop_ok, input bit abort);
    if (!abort) begin
      exp_q.push_back('{d, !stop_ok, cyc});
      n_sent++;
    end
    rx = 1'b0;
    hold(BITC);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (abort && i == 3) begin
        hold(20);
        reset = 1'b1;
        rx = 1'b1;
        hold(1);
        reset = 1'b0;
        last_d = 8'h00;
        last_fe = 1'b0;
        check("abort_dout", dout, 8'h00);
        check("abort_ferr", frame_err, 0);
        check("abort_done", rx_done_tick, 0);
        return;
      end
      hold(BITC);
    end
    if (stop_ok) begin
      rx = 1'b1;
      hold(BITC);
    end else begin
      rx = 1'b0;
      hold(40);
      rx = 1'b1;
      hold(BITC - 40);
    end
  endtask
  initial begin
    int n0;
    hold(3);
    reset = 1'b0;
    check("rst_dout", dout, 8'h00);
    check("rst_ferr", frame_err, 0);
    check("rst_done", rx_done_tick, 0);
    hold(1000);
    check("idle_pulses", pulse_q.size(), 0);
    check("idle_dout", dout, 8'h00);
    send(8'hA5, 1'b1, 1'b0);
    hold(60);
    check("a5_pulses", pulse_q.size(), 1);
    rx = 1'b0;
    hold(12);
    rx = 1'b1;
    hold(100);
    check("glitch_pulses", pulse_q.size(), 1);
    check("glitch_dout", dout, 8'hA5);
    send(8'h3C, 1'b0, 1'b0);
    hold(100);
    check("err_hold", frame_err, 1);
    send(8'h00, 1'b1, 1'b0);
    hold(60);
    check("err_clear", frame_err, 0);
    n0 = pulse_q.size();
    send(8'h55, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    hold(60);
    check("b2b_pulses", pulse_q.size(), n0 + 2);
    if (pulse_q.size() >= n0 + 2) check("b2b_gap", pulse_q[n0+1] - pulse_q[n0], 640);
    check("b2b_dout", dout, 8'hFF);
    n0 = pulse_q.size();
    send(8'h81, 1'b1, 1'b1);
    hold(200);
    check("abort_no_pulse", pulse_q.size(), n0);
    send(8'h81, 1'b1, 1'b0);
    hold(60);
    check("after_abort_dout", dout, 8'h81);
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      logic ok;
      d = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send(d, ok, 1'b0);
      hold($urandom_range(0, 80) + (ok ? 0 : 40));
      check("rnd_dout_hold", dout, last_d);
      check("rnd_ferr_hold", frame_err, last_fe);
    end
    hold(700);
    check("queue_drained", exp_q.size(), 0);
    check("total_pulses", pulse_q.size(), n_sent);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_unit.md
# uart_rx_unit

Serial-to-parallel UART receiver. Consumes the oversampling tick from the baud-rate generator (16 ticks per bit period) and the raw `rx` line. Recovers 8N1-style frames (configurable data bits and stop ticks), presents the received byte with a one-cycle completion pulse and reports a framing error. Feeds the receive FIFO / interface stage downstream.

## Interface
- `DBIT`, default 8: data bits per frame, 5..8.
- `SB_TICK`, default 16: oversampling ticks spent in the stop phase (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `rx` input 1: raw serial line, idle high, asynchronous to `clk`.
- `s_tick` input 1: one-`clk` pulse at 16× baud, from the baud-rate generator.
- `dout` output DBIT: last received data word, LSB received first.
- `rx_done_tick` output 1: one-`clk` pulse when a frame completes.
- `frame_err` output 1: stop-bit sample of the last completed frame was low.

## Operation
- `rx` passes through a 2-flop synchronizer, and both flops reset to 1. All FSM decisions use the synchronized value `rx_s`.
- Registers:
  - state: IDLE/START/DATA/STOP.
  - tick counter `s`: 4 bits, wide enough for SB_TICK-1, so 5 bits at SB_TICK=32. Size it to $clog2(SB_TICK).
  - bit counter `n`: $clog2(DBIT) bits.
  - shift register `b`: DBIT bits.
  - `frame_err` register.
- IDLE: when `rx_s`==0, go to START and set s=0. `s_tick` is not required to leave IDLE.
- START: on each `s_tick`:
  - If s==7 (mid start bit) and `rx_s`==0: go to DATA with s=0, n=0.
  - If s==7 and `rx_s`==1: treat as a glitch and return to IDLE with no pulse and no output change.
  - Otherwise s increments.
- DATA: on each `s_tick`:
  - If s==15: set s=0 and b={rx_s, b[DBIT-1:1]}. If n==DBIT-1, go to STOP; else n increments.
  - Otherwise s increments.
- STOP: on each `s_tick`:
  - If s==SB_TICK-1: return to IDLE and assert `rx_done_tick` for that cycle. `dout` takes the final `b`; `frame_err` takes ~`rx_s`.
  - Otherwise s increments.
- `dout` is a dedicated register updated only at frame completion. It holds its value between frames and across glitch aborts.
- A frame with a framing error is still delivered (`rx_done_tick`=1, `dout` valid); downstream decides whether to drop it.
- Without `s_tick`, no state changes occur except the IDLE→START transition.
- A new start edge is recognised in the first IDLE cycle after STOP. There is no dead time.

## Timing
- Reset values: state=IDLE, s=0, n=0, b=0, `dout`=0, `rx_done_tick`=0, `frame_err`=0, synchronizer=1.
- Reset asserted mid-frame aborts immediately to the reset values with no pulse.
- Input latency: 2 `clk` from `rx` to `rx_s`. Start detection takes one further cycle.
- Sampling points: 8 ticks into the start bit, then every 16 ticks, which is mid-bit. The stop sample is taken at SB_TICK ticks after the last data sample.
- Output timing: `rx_done_tick` is high for exactly one `clk`, in the cycle after the `s_tick` with s==SB_TICK-1 in STOP. `dout` and `frame_err` are valid from that same cycle.
- Simultaneous `s_tick` and reset: reset wins.
- Counter wrap: s never exceeds 15 in START/DATA or SB_TICK-1 in STOP.

## Structure
- Shared package `uart_pkg`:
  - state encoding as a 2-bit localparam set: IDLE=0, START=1, DATA=2, STOP=3.
  - default DBIT and SB_TICK.
  - the oversampling constant OVS=16, with mid-bit = OVS/2-1 = 7.
- Sub-module `sync_2ff`: the `rx` synchronizer, also reusable for other async inputs.
- FSM, counters and shift register stay in `uart_rx_unit` as one registered state block plus next-state logic.

## Test plan
In all scenarios the bench drives `s_tick` once every 4 `clk`, so one bit lasts 64 `clk`.
- Reset then idle line: `rx`=1 for 1000 clk → `dout`=0, `frame_err`=0, no `rx_done_tick`.
- Frame 0xA5, 1 stop bit → a single `rx_done_tick` ~ (10 bits × 64 clk − 32 + 3) after the start edge; `dout`=0xA5, `frame_err`=0.
- Start glitch: `rx` low for 12 clk (3 ticks), then high → FSM returns to IDLE, no pulse, `dout` unchanged.
- Frame 0x3C with stop bit driven low → `rx_done_tick`=1, `dout`=0x3C, `frame_err`=1. The next clean frame 0x00 clears `frame_err` to 0.
- Back-to-back frames 0x55, 0xFF with no idle gap → two pulses exactly 640 clk apart, `dout`=0x55 then 0xFF.
- Reset pulsed mid-DATA of frame 0x81 → outputs return to reset values immediately, no pulse. A following frame 0x81 is received correctly.
